// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_decoder.sv
// Binary-to-one-hot decoder with an enable; all-zero output when disabled.
module rr_arbiter_decoder #(
    parameter int unsigned ONE_HOT_WIDTH = 4
) (
    input  logic [$clog2(ONE_HOT_WIDTH)-1:0] idx,
    input  logic                             en,
    output logic [ONE_HOT_WIDTH-1:0]         one_hot
);

    localparam int unsigned IW = $clog2(ONE_HOT_WIDTH);

    always_comb begin
        one_hot = '0;
        for (int k = 0; k < int'(ONE_HOT_WIDTH); k++) begin
            one_hot[k] = en && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer, zero-bubble hand-over
// and hold-time preemption after MAX_HOLD consecutive granted cycles.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM  = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [REQ_NUM-1:0]         i_req,
    output logic [REQ_NUM-1:0]         o_gnt,
    output logic [$clog2(REQ_NUM)-1:0] o_gnt_idx,
    output logic                       o_gnt_valid
);

    localparam int unsigned IW = $clog2(REQ_NUM);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [REQ_NUM-1:0] search_mask;
    logic               owner_req;
    logic               found;
    logic [IW-1:0]      sel;
    logic               hold_expired;

    // o_gnt is zero in idle, so masking it out excludes only a current owner.
    assign search_mask  = i_req & ~o_gnt;
    assign owner_req    = |(i_req & o_gnt);
    assign hold_expired = (cnt_q == CW'(MAX_HOLD));

    always_comb begin
        int pos;
        found = 1'b0;
        sel   = '0;
        pos   = 0;
        for (int i = 0; i < int'(REQ_NUM); i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= int'(REQ_NUM)) begin
                pos = pos - int'(REQ_NUM);
            end
            if (!found && search_mask[pos]) begin
                found = 1'b1;
                sel   = IW'(pos);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBusy;
                    idx_d   = sel;
                    cnt_d   = CW'(1);
                    ptr_d   = (sel == IW'(REQ_NUM - 1)) ? '0 : sel + 1'b1;
                end
            end
            StBusy: begin
                if (!owner_req || (hold_expired && found)) begin
                    if (found) begin
                        idx_d = sel;
                        cnt_d = CW'(1);
                        ptr_d = (sel == IW'(REQ_NUM - 1)) ? '0 : sel + 1'b1;
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (!hold_expired) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_gnt_valid = (state_q == StBusy);
    assign o_gnt_idx   = idx_q;

    rr_arbiter_decoder #(
        .ONE_HOT_WIDTH(REQ_NUM)
    ) u_decoder (
        .idx    (o_gnt_idx),
        .en     (o_gnt_valid),
        .one_hot(o_gnt)
    );

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4, meaning the number of requesters (legal range 2..64, non-power-of-two allowed).
REQ-002 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive granted cycles before preemption when others wait (legal range >= 1).
REQ-003 SHALL have port i_clk  input  1  system clock; all state updates occur on the rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_req  input  REQ_NUM  per-requester request level; bit k belongs to requester k.
REQ-006 SHALL have port o_gnt  output  REQ_NUM  one-hot grant, all-zero when no grant.
REQ-007 SHALL have port o_gnt_idx  output  $clog2(REQ_NUM)  binary index of the current owner.
REQ-008 SHALL have port o_gnt_valid  output  1  high while any grant is active.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-010 SHALL keep a rotating priority pointer PTR of width $clog2(REQ_NUM); the search order is PTR, PTR+1, ..., wrapping from REQ_NUM-1 to 0.
REQ-011 In IDLE with i_req != 0 at a rising edge, SHALL grant the first set request in search order, enter BUSY and set PTR = granted index + 1 mod REQ_NUM; o_gnt is valid in the cycle after the request is sampled (1-cycle latency).
REQ-012 In IDLE with i_req == 0, SHALL stay in IDLE with all outputs zero.
REQ-013 In BUSY, SHALL keep a hold counter that is 1 in the first granted cycle, increments each cycle the owner keeps the grant, and saturates at MAX_HOLD.
REQ-014 In BUSY, SHALL keep the grant unchanged while i_req[owner] = 1 and either the counter < MAX_HOLD or no other request bit is set.
REQ-015 When i_req[owner] is sampled 0, SHALL in the same edge re-arbitrate among the remaining requests in search order from PTR (zero-bubble hand-over); if none remain, SHALL return to IDLE and clear o_gnt and o_gnt_valid.
REQ-016 When the counter equals MAX_HOLD and any other request bit is set, SHALL preempt the owner and grant the next requester in search order, excluding the owner.
REQ-017 On every new grant, including re-grant after preemption, SHALL reset the hold counter to 1 and advance PTR to new index + 1 mod REQ_NUM.
REQ-018 SHALL never grant a requester whose request bit was 0 at the arbitration edge.
REQ-019 SHALL drive o_gnt as the one-hot decode of o_gnt_idx, gated by o_gnt_valid, so exactly one or zero bits are set.
REQ-020 o_gnt_idx SHALL be 0 whenever o_gnt_valid = 0.
REQ-021 SHALL ignore request bits that rise or fall between edges; only sampled values matter.

Reset
REQ-022 On i_rst = 1, SHALL immediately, without waiting for a clock edge, force state IDLE, PTR = 0, counter = 0, o_gnt = 0, o_gnt_idx = 0 and o_gnt_valid = 0.
REQ-023 A reset asserted mid-grant SHALL abort the grant with no partial hand-over; the first arbitration after reset release starts from PTR = 0.

Structure
REQ-024 FSM state encodings (IDLE, BUSY) SHALL be defined as constants in a shared package, rr_arb_pkg; index widths SHALL be derived locally with $clog2(REQ_NUM).
REQ-025 The one-hot output SHALL be produced by instantiating the team's existing decoder module with ONE_HOT_WIDTH = REQ_NUM, driven by o_gnt_idx; no other sub-module.

Verification
REQ-026 Reset: assert i_rst with i_req = 4'b1111 -> o_gnt = 0, o_gnt_valid = 0 and o_gnt_idx = 0 immediately; after release the first grant is index 0.
REQ-027 Full load: i_req = 4'b1111 held (REQ_NUM = 4, MAX_HOLD = 8) -> grants 0, 1, 2, 3, 0 in turn, each for exactly 8 cycles with no gap.
REQ-028 Lone requester: i_req = 4'b0100 held for 20 cycles -> o_gnt = 4'b0100 for every cycle from cycle 1, with no preemption.
REQ-029 Hand-over: owner 1 (PTR = 2) drops its request while i_req = 4'b1001 -> the next cycle o_gnt = 4'b1000 (index 3); when all requests drop -> IDLE and o_gnt = 0 the next cycle.
REQ-030 Wrap-around: REQ_NUM = 17, owner 16 drops its request while only i_req[0] = 1 -> o_gnt_idx = 0 the next cycle and PTR = 1.
REQ-031 Mid-operation reset: assert i_rst for a partial cycle during BUSY with owner 2 -> outputs clear asynchronously; after release with i_req = 4'b0110 -> grant index 1.
